// File: rtl/bias_pkg.sv
// Shared constants and the saturating-add helper for the bias-add datapath.
// The helper works on a wide signed carrier so one function serves any lane width.
package bias_pkg;

    localparam int DATA_W = 18;
    localparam int CALC_W = 64;

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // a and b are sign-extended w-bit values; the result is clamped to the w-bit range.
    function automatic logic [CALC_W-1:0] sat_add(
        input logic [CALC_W-1:0] a,
        input logic [CALC_W-1:0] b,
        input int unsigned       w
    );
        logic signed [CALC_W-1:0] s;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        s  = $signed(a) + $signed(b);
        hi = $signed((CALC_W'(1) << (w - 1)) - CALC_W'(1));
        lo = -$signed(CALC_W'(1) << (w - 1));
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/bias_lane.sv
// One lane of the bias stage: saturating add of accumulator and bias, then optional ReLU.
// Purely combinational; the top registers the result on accept.
module bias_lane
    import bias_pkg::*;
#(
    parameter int DATA_W = bias_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] bias,
    input  logic              relu_en,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] sat;

    assign sat = DATA_W'(sat_add({{(CALC_W-DATA_W){acc[DATA_W-1]}}, acc},
                                 {{(CALC_W-DATA_W){bias[DATA_W-1]}}, bias},
                                 DATA_W));

    // ReLU follows saturation so a clamped negative still becomes zero.
    assign result = (relu_en && sat[DATA_W-1]) ? '0 : sat;

endmodule

// File: rtl/bias_add_stage.sv
// Adds a per-group, runtime-loadable bias vector to each adder-tree output beat,
// with saturation and optional ReLU, behind a one-deep valid/ready output register.
module bias_add_stage
    import bias_pkg::*;
#(
    parameter int N_adder_tree = 16,
    parameter int DATA_W       = bias_pkg::DATA_W,
    parameter int N_GROUPS     = 4,
    parameter int GRP_W        = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           relu_en,
    input  logic                           grp_clr,
    input  logic                           bias_wr_en,
    input  logic [GRP_W-1:0]               bias_wr_grp,
    input  logic [N_adder_tree*DATA_W-1:0] bias_wr_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_adder_tree*DATA_W-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_adder_tree*DATA_W-1:0] out_data,
    output logic [GRP_W-1:0]               out_grp,
    output logic                           out_last
);

    localparam int               VEC_W    = N_adder_tree * DATA_W;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(N_GROUPS - 1);

    logic [VEC_W-1:0] bias_mem [N_GROUPS];
    logic [VEC_W-1:0] bias_cur;
    logic [VEC_W-1:0] lane_sum;

    logic [GRP_W-1:0] grp_reg;
    logic [GRP_W-1:0] grp_next;

    logic             out_valid_reg;
    logic [VEC_W-1:0] out_data_reg;
    logic [GRP_W-1:0] out_grp_reg;
    logic             out_last_reg;

    logic             accept;

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    // Combinational read of the current group: a same-edge write is seen only by later beats.
    assign bias_cur = bias_mem[grp_reg];

    generate
        for (genvar gi = 0; gi < N_GROUPS; gi++) begin : g_bias_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bias_mem[gi] <= '0;
                end else if (bias_wr_en && (bias_wr_grp == GRP_W'(gi))) begin
                    bias_mem[gi] <= bias_wr_data;
                end
            end
        end

        for (genvar gi = 0; gi < N_adder_tree; gi++) begin : g_lane
            bias_lane #(
                .DATA_W (DATA_W)
            ) u_lane (
                .acc     (in_data[DATA_W*gi +: DATA_W]),
                .bias    (bias_cur[DATA_W*gi +: DATA_W]),
                .relu_en (relu_en),
                .result  (lane_sum[DATA_W*gi +: DATA_W])
            );
        end
    endgenerate

    // Clear wins over the post-accept increment.
    always_comb begin
        grp_next = grp_reg;
        if (grp_clr) begin
            grp_next = '0;
        end else if (accept) begin
            grp_next = (grp_reg == LAST_GRP) ? '0 : grp_reg + GRP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_grp_reg   <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            grp_reg <= grp_next;
            if (in_ready) begin
                out_valid_reg <= in_valid;
            end
            if (accept) begin
                out_data_reg <= lane_sum;
                out_grp_reg  <= grp_reg;
                out_last_reg <= (grp_reg == LAST_GRP);
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_grp   = out_grp_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_bias_add_stage.sv
// Self-checking bench for bias_add_stage: directed vector table, hand-written corner
// sequences and a randomized run, all compared against a transaction-level model.
module tb_bias_add_stage;

    localparam int N  = 16;
    localparam int DW = 18;
    localparam int G  = 4;
    localparam int GW = 2;
    localparam int VW = N * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          relu_en = 1'b0;
    logic          grp_clr = 1'b0;
    logic          bias_wr_en = 1'b0;
    logic [GW-1:0] bias_wr_grp = '0;
    logic [VW-1:0] bias_wr_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [VW-1:0] out_data;
    logic [GW-1:0] out_grp;
    logic          out_last;

    bias_add_stage #(
        .N_adder_tree (N),
        .DATA_W       (DW),
        .N_GROUPS     (G),
        .GRP_W        (GW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .relu_en      (relu_en),
        .grp_clr      (grp_clr),
        .bias_wr_en   (bias_wr_en),
        .bias_wr_grp  (bias_wr_grp),
        .bias_wr_data (bias_wr_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_grp      (out_grp),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: bias table, group counter and the one held output item.
    logic [VW-1:0] m_tbl [G];
    int            m_grp = 0;
    bit            m_pending = 0;
    logic [VW-1:0] m_data = '0;
    int            m_out_grp = 0;
    bit            m_last = 0;

    typedef struct {
        logic [DW-1:0] bias;
        logic [DW-1:0] din;
        bit            relu;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_lane(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit relu);
        int s;
        int hi;
        int lo;
        hi = (1 << (DW - 1)) - 1;
        lo = -(1 << (DW - 1));
        s  = int'($signed(a)) + int'($signed(b));
        if (s > hi) s = hi;
        else if (s < lo) s = lo;
        if (relu && s < 0) s = 0;
        return s[DW-1:0];
    endfunction

    function automatic logic [VW-1:0] ref_vec(input logic [VW-1:0] d, input logic [VW-1:0] b, input bit relu);
        logic [VW-1:0] r;
        for (int l = 0; l < N; l++) begin
            r[l*DW +: DW] = ref_lane(d[l*DW +: DW], b[l*DW +: DW], relu);
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int l = 0; l < N; l++) begin
            v[l*DW +: DW] = DW'($urandom);
        end
        return v;
    endfunction

    task automatic idle();
        in_valid   = 1'b0;
        bias_wr_en = 1'b0;
        grp_clr    = 1'b0;
        relu_en    = 1'b0;
    endtask

    // Called just after an active edge with inputs set; checks outputs, advances the model,
    // then returns just after the next active edge.
    task automatic cycle();
        bit acc;
        bit exp_rdy;
        #1;
        exp_rdy = !m_pending || out_ready;
        check("in_ready", VW'(in_ready), VW'(exp_rdy));
        check("out_valid", VW'(out_valid), VW'(m_pending));
        if (m_pending) begin
            check("out_data", out_data, m_data);
            check("out_grp", VW'(out_grp), VW'(m_out_grp));
            check("out_last", VW'(out_last), VW'(m_last));
        end
        acc = in_valid && exp_rdy;
        if (m_pending && out_ready) m_pending = 0;
        if (acc) begin
            m_data    = ref_vec(in_data, m_tbl[m_grp], relu_en);
            m_out_grp = m_grp;
            m_last    = (m_grp == G - 1);
            m_pending = 1;
            $display("beat grp=%0d relu=%0d lane0 in=%h out=%h", m_grp, relu_en, in_data[DW-1:0], m_data[DW-1:0]);
        end
        if (grp_clr) m_grp = 0;
        else if (acc) m_grp = (m_grp + 1) % G;
        if (bias_wr_en) m_tbl[bias_wr_grp] = bias_wr_data;
        @(posedge clk);
        #1;
    endtask

    task automatic write_bias(input int g, input logic [VW-1:0] v);
        idle();
        bias_wr_en   = 1'b1;
        bias_wr_grp  = GW'(g);
        bias_wr_data = v;
        cycle();
        bias_wr_en = 1'b0;
    endtask

    task automatic send(input logic [VW-1:0] v, input bit relu);
        idle();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = v;
        relu_en   = relu;
        cycle();
        in_valid = 1'b0;
        relu_en  = 1'b0;
    endtask

    initial begin
        logic [VW-1:0] v;
        logic [VW-1:0] b;

        for (int g = 0; g < G; g++) m_tbl[g] = '0;

        vecs[0] = '{18'h003DB, 18'h00010, 1'b0, 18'h003EB};
        vecs[1] = '{18'h3F472, 18'h00010, 1'b0, 18'h3F482};
        vecs[2] = '{18'h1FF00, 18'h00200, 1'b0, 18'h1FFFF};
        vecs[3] = '{18'h20100, 18'h3FD00, 1'b0, 18'h20000};
        vecs[4] = '{18'h20100, 18'h3FD00, 1'b1, 18'h00000};
        vecs[5] = '{18'h00005, 18'h3FFFA, 1'b0, 18'h3FFFF};
        vecs[6] = '{18'h00005, 18'h3FFFA, 1'b1, 18'h00000};
        vecs[7] = '{18'h0FFFF, 18'h10000, 1'b0, 18'h1FFFF};
        vecs[8] = '{18'h3FFFF, 18'h00001, 1'b1, 18'h00000};
        vecs[9] = '{18'h1FFFF, 18'h3FFFF, 1'b0, 18'h1FFFE};

        // Reset state
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        check("rst_out_valid", VW'(out_valid), '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_grp", VW'(out_grp), '0);
        check("rst_out_last", VW'(out_last), '0);
        @(posedge clk);
        #1;

        // Directed vector table: lane 0 carries the vector, other lanes are random
        for (int i = 0; i < 10; i++) begin
            b = rand_vec();
            b[DW-1:0] = vecs[i].bias;
            write_bias(i % G, b);
            v = rand_vec();
            v[DW-1:0] = vecs[i].din;
            send(v, vecs[i].relu);
            check($sformatf("vec%0d_lane0", i), VW'(out_data[DW-1:0]), VW'(vecs[i].exp));
            check($sformatf("vec%0d_grp", i), VW'(out_grp), VW'(i % G));
            check($sformatf("vec%0d_last", i), VW'(out_last), VW'(i % G == G - 1));
        end

        // Backpressure: one beat held for 5 cycles, then drain with group sequencing
        idle();
        grp_clr = 1'b1;
        cycle();
        grp_clr   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rand_vec();
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("bp_in_ready", VW'(in_ready), '0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("drain_valid", VW'(out_valid), VW'(1));
            check("drain_grp", VW'(out_grp), VW'(k % G));
            check("drain_last", VW'(out_last), VW'(k == 3));
            in_data = rand_vec();
            cycle();
        end
        idle();
        cycle();

        // Same-cycle bias write and read of group 2
        idle();
        grp_clr = 1'b1;
        cycle();
        grp_clr = 1'b0;
        b = rand_vec();
        b[DW-1:0] = 18'h00100;
        write_bias(2, b);
        send(rand_vec(), 1'b0);
        send(rand_vec(), 1'b0);
        b = rand_vec();
        b[DW-1:0] = 18'h00200;
        v = rand_vec();
        v[DW-1:0] = 18'h00001;
        bias_wr_en   = 1'b1;
        bias_wr_grp  = GW'(2);
        bias_wr_data = b;
        in_valid     = 1'b1;
        in_data      = v;
        out_ready    = 1'b1;
        cycle();
        idle();
        check("rbw_old_bias", VW'(out_data[DW-1:0]), VW'(18'h00101));
        check("rbw_grp", VW'(out_grp), VW'(2));
        for (int k = 0; k < 3; k++) send(rand_vec(), 1'b0);
        send(v, 1'b0);
        check("rbw_new_bias", VW'(out_data[DW-1:0]), VW'(18'h00201));
        check("rbw_new_grp", VW'(out_grp), VW'(2));

        // grp_clr together with an accept at group 2
        idle();
        grp_clr = 1'b1;
        cycle();
        grp_clr = 1'b0;
        send(rand_vec(), 1'b0);
        send(rand_vec(), 1'b0);
        in_valid = 1'b1;
        in_data  = rand_vec();
        grp_clr  = 1'b1;
        cycle();
        idle();
        check("clr_same_beat_grp", VW'(out_grp), VW'(2));
        send(rand_vec(), 1'b0);
        check("clr_next_beat_grp", VW'(out_grp), VW'(0));

        // Asynchronous reset while an output is held
        idle();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rand_vec();
        cycle();
        idle();
        #3 rst = 1'b1;
        #1;
        check("async_rst_valid", VW'(out_valid), '0);
        check("async_rst_grp", VW'(out_grp), '0);
        check("async_rst_data", out_data, '0);
        m_pending = 0;
        m_grp     = 0;
        for (int g = 0; g < G; g++) m_tbl[g] = '0;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        v = rand_vec();
        send(v, 1'b0);
        check("post_rst_passthru", out_data, v);
        check("post_rst_grp", VW'(out_grp), '0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bias_wr_en   = ($urandom_range(0, 3) == 0);
            bias_wr_grp  = GW'($urandom_range(0, G - 1));
            bias_wr_data = rand_vec();
            in_valid     = $urandom_range(0, 1) == 1;
            in_data      = rand_vec();
            relu_en      = $urandom_range(0, 1) == 1;
            out_ready    = ($urandom_range(0, 3) != 0);
            grp_clr      = ($urandom_range(0, 15) == 0);
            cycle();
        end
        idle();
        out_ready = 1'b1;
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
